// File: rtl/vga_blinken_grid_pkg.sv
// Package for vga_blinken_grid.
// Holds the display timing constants used by the grid renderer, the LFSR taps,
// the default lamp colours, the S1 pipeline record and small helper functions.
package vga_blinken_grid_pkg;

    // 640x480 timing: the first blank line follows the last visible one.
    localparam int unsigned VGA_RES_V      = 480;
    // Inactive sync levels. Both syncs are active-low in this mode, so they idle high.
    localparam logic        VGA_SYNC_H_POL = 1'b1;
    localparam logic        VGA_SYNC_V_POL = 1'b1;

    // Galois LFSR taps, shift-right form.
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    // Default colours, RGB444.
    localparam logic [11:0] DEF_COLOR_ON   = 12'hF80;
    localparam logic [11:0] DEF_COLOR_OFF  = 12'h210;
    localparam logic [11:0] DEF_COLOR_GRID = 12'h444;

    // Everything the second stage needs about one input pixel.
    typedef struct packed {
        logic [7:0] col;
        logic [7:0] row;
        logic       in_image;
        logic       gridline;
        logic       sync_h;
        logic       sync_v;
    } s1_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Cell coordinate saturated to 8 bits, so a huge location can never
    // wrap around into a valid cell.
    function automatic logic [7:0] cell_coord(input logic [12:0] loc, input int unsigned shift);
        logic [12:0] c;
        c = loc >> shift;
        return (|c[12:8]) ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/vga_blinken_grid_lfsr16.sv
// blinken_lfsr16: 16-bit Galois LFSR that advances one step when 'step' is high.
// Ports:
//   PIXEL_CLK  pixel clock
//   RESET      synchronous, active-high; loads seed (a zero seed loads 16'h0001)
//   step       advance the register by one state
//   seed       reset value
//   value      current LFSR state
module blinken_lfsr16
    import vga_blinken_grid_pkg::*;
(
    input  logic        PIXEL_CLK,
    input  logic        RESET,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            // The all-zero state is a fixed point of the LFSR; never start there.
            value <= (seed == '0) ? 16'h0001 : seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/vga_blinken_grid.sv
// vga_blinken_grid: pixel generator that sits directly behind vga_sync.
// Renders a GRID_W x GRID_H grid of lamp cells; one pseudo-random lamp toggles
// every FRAMES_PER_STEP frames. Two-stage pipeline, syncs delayed to match rgb.
// Ports:
//   PIXEL_CLK   pixel clock shared with vga_sync
//   RESET       synchronous, active-high
//   locX, locY  vga_sync counters
//   in_image    vga_sync visible-area flag
//   sync_h_in   horizontal sync, polarity already applied
//   sync_v_in   vertical sync, polarity already applied
//   rgb         {R,G,B} 4 bits each, 0 outside the image
//   sync_h      sync_h_in delayed 2 cycles
//   sync_v      sync_v_in delayed 2 cycles
//   frame_tick  one-cycle pulse per frame, the cycle after the first blank line starts
module vga_blinken_grid
    import vga_blinken_grid_pkg::*;
#(
    parameter int unsigned CELL_SHIFT      = 5,
    parameter int unsigned GRID_W          = 20,
    parameter int unsigned GRID_H          = 15,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [11:0] COLOR_ON        = DEF_COLOR_ON,
    parameter logic [11:0] COLOR_OFF       = DEF_COLOR_OFF,
    parameter logic [11:0] COLOR_GRID      = DEF_COLOR_GRID
) (
    input  logic        PIXEL_CLK,
    input  logic        RESET,
    input  logic [12:0] locX,
    input  logic [12:0] locY,
    input  logic        in_image,
    input  logic        sync_h_in,
    input  logic        sync_v_in,
    output logic [11:0] rgb,
    output logic        sync_h,
    output logic        sync_v,
    output logic        frame_tick
);

    localparam int unsigned NCELLS    = GRID_W * GRID_H;
    localparam int unsigned IDX_W     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [12:0] CELL_MASK = 13'((1 << CELL_SHIFT) - 1);

    s1_t               s1;
    logic [NCELLS-1:0] lamps;
    logic [15:0]       frame_cnt;
    logic [15:0]       lfsr_q;
    logic [8:0]        lfsr_nx_lo;
    logic              frame_evt;
    logic              step;

    logic [7:0]        t_col;
    logic [7:0]        t_row;
    logic              t_hit;
    logic [IDX_W-1:0]  t_idx;

    logic              rd_hit;
    logic [IDX_W-1:0]  rd_idx;
    logic [11:0]       pix_c;

    assign frame_evt = (locX == '0) && (locY == 13'(VGA_RES_V));
    assign step      = frame_evt && (frame_cnt == 16'(FRAMES_PER_STEP - 1));

    blinken_lfsr16 u_lfsr (
        .PIXEL_CLK (PIXEL_CLK),
        .RESET     (RESET),
        .step      (step),
        .seed      (LFSR_SEED),
        .value     (lfsr_q)
    );

    // The lamp to toggle is addressed by the state the LFSR is stepping into,
    // so the selection is taken from the next value, not the registered one.
    assign lfsr_nx_lo = 9'(lfsr_next(lfsr_q));

    always_comb begin
        t_col = {3'b000, lfsr_nx_lo[4:0]};
        t_row = {4'b0000, lfsr_nx_lo[8:5]};
        t_hit = (t_col < 8'(GRID_W)) && (t_row < 8'(GRID_H));
        t_idx = '0;
        if (t_hit) begin
            t_idx = IDX_W'(32'(t_row) * GRID_W + 32'(t_col));
        end
    end

    // Stage 1: cell coordinates, gridline flag, visible flag and syncs.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            s1.col      <= '0;
            s1.row      <= '0;
            s1.in_image <= 1'b0;
            s1.gridline <= 1'b0;
            s1.sync_h   <= VGA_SYNC_H_POL;
            s1.sync_v   <= VGA_SYNC_V_POL;
        end else begin
            s1.col      <= cell_coord(locX, CELL_SHIFT);
            s1.row      <= cell_coord(locY, CELL_SHIFT);
            s1.in_image <= in_image;
            s1.gridline <= ((locX & CELL_MASK) == '0) || ((locY & CELL_MASK) == '0);
            s1.sync_h   <= sync_h_in;
            s1.sync_v   <= sync_v_in;
        end
    end

    // Stage 2 colour select; the range test guards the lamp read.
    always_comb begin
        rd_hit = s1.in_image && (s1.col < 8'(GRID_W)) && (s1.row < 8'(GRID_H));
        rd_idx = '0;
        pix_c  = '0;
        if (rd_hit) begin
            rd_idx = IDX_W'(32'(s1.row) * GRID_W + 32'(s1.col));
            if (s1.gridline) begin
                pix_c = COLOR_GRID;
            end else if (lamps[rd_idx]) begin
                pix_c = COLOR_ON;
            end else begin
                pix_c = COLOR_OFF;
            end
        end
    end

    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            rgb        <= '0;
            sync_h     <= VGA_SYNC_H_POL;
            sync_v     <= VGA_SYNC_V_POL;
            frame_tick <= 1'b0;
        end else begin
            rgb        <= pix_c;
            sync_h     <= s1.sync_h;
            sync_v     <= s1.sync_v;
            frame_tick <= frame_evt;
        end
    end

    // Frame counter and lamp store; updates land in vertical blanking.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            frame_cnt <= '0;
            lamps     <= '0;
        end else if (frame_evt) begin
            if (step) begin
                frame_cnt <= '0;
                if (t_hit) begin
                    lamps[t_idx] <= ~lamps[t_idx];
                end
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_blinken_grid.sv
// Directed bench for vga_blinken_grid. Three instances share the stimulus:
//   a: FRAMES_PER_STEP=1, seed ACE1
//   b: FRAMES_PER_STEP=1, seed E270 (first two steps land outside the grid)
//   c: FRAMES_PER_STEP=8, seed ACE1
// Frames are compressed: the bench jumps straight to locX=0, locY=480.
module tb_vga_blinken_grid;

    logic        PIXEL_CLK = 1'b0;
    logic        RESET;
    logic [12:0] locX;
    logic [12:0] locY;
    logic        in_image;
    logic        sync_h_in;
    logic        sync_v_in;

    logic [11:0] rgb_a, rgb_b, rgb_c;
    logic        sh_a, sv_a, ft_a;
    logic        sh_b, sv_b, ft_b;
    logic        sh_c, sv_c, ft_c;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [11:0] ON   = 12'hF80;
    localparam logic [11:0] OFF  = 12'h210;
    localparam logic [11:0] GRID = 12'h444;
    localparam logic [11:0] BLK  = 12'h000;

    always #5 PIXEL_CLK = ~PIXEL_CLK;

    vga_blinken_grid #(.FRAMES_PER_STEP(1), .LFSR_SEED(16'hACE1)) dut_a (
        .PIXEL_CLK(PIXEL_CLK), .RESET(RESET), .locX(locX), .locY(locY),
        .in_image(in_image), .sync_h_in(sync_h_in), .sync_v_in(sync_v_in),
        .rgb(rgb_a), .sync_h(sh_a), .sync_v(sv_a), .frame_tick(ft_a)
    );

    vga_blinken_grid #(.FRAMES_PER_STEP(1), .LFSR_SEED(16'hE270)) dut_b (
        .PIXEL_CLK(PIXEL_CLK), .RESET(RESET), .locX(locX), .locY(locY),
        .in_image(in_image), .sync_h_in(sync_h_in), .sync_v_in(sync_v_in),
        .rgb(rgb_b), .sync_h(sh_b), .sync_v(sv_b), .frame_tick(ft_b)
    );

    vga_blinken_grid #(.FRAMES_PER_STEP(8), .LFSR_SEED(16'hACE1)) dut_c (
        .PIXEL_CLK(PIXEL_CLK), .RESET(RESET), .locX(locX), .locY(locY),
        .in_image(in_image), .sync_h_in(sync_h_in), .sync_v_in(sync_v_in),
        .rgb(rgb_c), .sync_h(sh_c), .sync_v(sv_c), .frame_tick(ft_c)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input logic img, input logic sh, input logic sv);
        @(negedge PIXEL_CLK);
        locX      = 13'(x);
        locY      = 13'(y);
        in_image  = img;
        sync_h_in = sh;
        sync_v_in = sv;
    endtask

    // Off-screen location that is not a frame event.
    task automatic idle();
        drive(1, 490, 1'b0, 1'b1, 1'b1);
    endtask

    // Drive one pixel and check all three instances two cycles later.
    task automatic pix(input int x, input int y, input logic img,
                       input logic [11:0] ea, input logic [11:0] eb, input logic [11:0] ec,
                       input string tag);
        drive(x, y, img, 1'b1, 1'b1);
        idle();
        @(negedge PIXEL_CLK);
        chk({tag, "/a"}, 16'(rgb_a), 16'(ea));
        chk({tag, "/b"}, 16'(rgb_b), 16'(eb));
        chk({tag, "/c"}, 16'(rgb_c), 16'(ec));
    endtask

    task automatic frame_event(input string tag);
        drive(0, 480, 1'b0, 1'b1, 1'b1);
        idle();
        chk({tag, "/tick_a"}, 16'(ft_a), 16'd1);
        chk({tag, "/tick_c"}, 16'(ft_c), 16'd1);
        @(negedge PIXEL_CLK);
        chk({tag, "/tick_a_off"}, 16'(ft_a), 16'd0);
        chk({tag, "/tick_c_off"}, 16'(ft_c), 16'd0);
    endtask

    initial begin
        // Reset held 3 cycles mid-line with active syncs on the inputs.
        RESET     = 1'b1;
        locX      = 13'd100;
        locY      = 13'd100;
        in_image  = 1'b1;
        sync_h_in = 1'b0;
        sync_v_in = 1'b0;
        repeat (3) @(posedge PIXEL_CLK);
        @(negedge PIXEL_CLK);
        chk("rst_rgb",  16'(rgb_a), 16'd0);
        chk("rst_sh",   16'(sh_a),  16'd1);
        chk("rst_sv",   16'(sv_a),  16'd1);
        chk("rst_tick", 16'(ft_a),  16'd0);
        RESET     = 1'b0;
        locX      = 13'd1;
        locY      = 13'd490;
        in_image  = 1'b0;
        sync_h_in = 1'b1;
        sync_v_in = 1'b1;

        // Rendering with every lamp dark.
        pix(33, 33, 1'b1, OFF, OFF, OFF, "p33_33");
        pix(32, 40, 1'b1, GRID, GRID, GRID, "p32_40");
        pix(40, 64, 1'b1, GRID, GRID, GRID, "p40_64");
        pix(700, 10, 1'b0, BLK, BLK, BLK, "p700_blank");
        pix(700, 10, 1'b1, BLK, BLK, BLK, "p700_colrange");
        pix(100, 480, 1'b1, BLK, BLK, BLK, "p100_rowrange");
        pix(8000, 8000, 1'b1, BLK, BLK, BLK, "p8000_far");
        pix(639, 479, 1'b1, OFF, OFF, OFF, "p639_479");
        pix(33, 33, 1'b0, BLK, BLK, BLK, "p33_noimg");
        pix(520, 100, 1'b1, OFF, OFF, OFF, "off_P");
        pix(456, 72, 1'b1, OFF, OFF, OFF, "off_Q");

        // sync_h alignment with rgb.
        drive(33, 33, 1'b1, 1'b0, 1'b1);
        idle();
        chk("sh_n1", 16'(sh_a), 16'd1);
        @(negedge PIXEL_CLK);
        chk("sh_n2", 16'(sh_a), 16'd0);
        chk("sh_n2_rgb", 16'(rgb_a), 16'(OFF));
        @(negedge PIXEL_CLK);
        chk("sh_n3", 16'(sh_a), 16'd1);

        // sync_v alignment with rgb.
        drive(32, 40, 1'b1, 1'b1, 1'b0);
        idle();
        chk("sv_n1", 16'(sv_a), 16'd1);
        @(negedge PIXEL_CLK);
        chk("sv_n2", 16'(sv_a), 16'd0);
        chk("sv_n2_rgb", 16'(rgb_a), 16'(GRID));
        @(negedge PIXEL_CLK);
        chk("sv_n3", 16'(sv_a), 16'd1);

        // a: E270 -> (16,3) on. b: 7138 skip. c: count 1.
        frame_event("e1");
        pix(520, 100, 1'b1, ON, OFF, OFF, "e1_P");
        pix(456, 72, 1'b1, OFF, OFF, OFF, "e1_Q");
        pix(512, 100, 1'b1, GRID, GRID, GRID, "e1_grid");

        // a: 7138 skip. b: 389C skip.
        frame_event("e2");
        pix(520, 100, 1'b1, ON, OFF, OFF, "e2_P");
        pix(456, 72, 1'b1, OFF, OFF, OFF, "e2_Q");

        // a: 389C skip. b: 1C4E -> (14,2) on.
        frame_event("e3");
        pix(456, 72, 1'b1, OFF, ON, OFF, "e3_Q");
        pix(520, 100, 1'b1, ON, OFF, OFF, "e3_P");

        // a: 1C4E -> (14,2) on. b: 0E27 -> (7,1) on.
        frame_event("e4");
        pix(456, 72, 1'b1, ON, ON, OFF, "e4_Q");
        pix(232, 40, 1'b1, OFF, ON, OFF, "e4_R");

        frame_event("e5");
        frame_event("e6");
        frame_event("e7");
        pix(520, 100, 1'b1, ON, OFF, OFF, "e7_P");

        // c steps on its 8th event: E270 -> (16,3) on.
        frame_event("e8");
        pix(520, 100, 1'b1, ON, OFF, ON, "e8_P");

        frame_event("e9");
        pix(520, 100, 1'b1, ON, OFF, ON, "e9_P");
        pix(616, 264, 1'b1, ON, ON, OFF, "e9_S");

        // Reset mid-visible with lamps lit.
        drive(520, 100, 1'b1, 1'b1, 1'b1);
        RESET = 1'b1;
        idle();
        RESET = 1'b0;
        chk("mrst_rgb", 16'(rgb_a), 16'd0);
        chk("mrst_sh",  16'(sh_a),  16'd1);
        pix(520, 100, 1'b1, OFF, OFF, OFF, "mrst_P");
        pix(456, 72, 1'b1, OFF, OFF, OFF, "mrst_Q");
        pix(616, 264, 1'b1, OFF, OFF, OFF, "mrst_S");

        // LFSRs and counters restart from their seeds.
        frame_event("e10");
        pix(520, 100, 1'b1, ON, OFF, OFF, "e10_P");
        pix(456, 72, 1'b1, OFF, OFF, OFF, "e10_Q");
        pix(616, 264, 1'b1, OFF, OFF, OFF, "e10_S");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
